// File: rtl/rca_serial_adder.sv
// Handshaked serial ripple-carry adder: adds N-bit operands W bits per clock
// through a W-bit ripple slice with a registered carry between slices.
module rca_serial_adder #(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int NS = N / W;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  generate
    if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
      $error("rca_serial_adder: need N >= 2, 1 <= W <= N and N %% W == 0");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [N-1:0]    acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    slice_sum;
  logic            slice_c;
  logic            slice_cmsb;
  logic [N-1:0]    acc_shift;

  // Ripple slice over the low W operand bits; slice_cmsb is the carry into
  // the slice's top bit, which on the last slice is the carry into bit N-1.
  always_comb begin
    slice_sum  = '0;
    slice_c    = carry_q;
    slice_cmsb = carry_q;
    for (int i = 0; i < W; i++) begin
      slice_cmsb   = slice_c;
      slice_sum[i] = a_q[i] ^ b_q[i] ^ slice_c;
      slice_c      = (a_q[i] & b_q[i]) | (slice_c & (a_q[i] ^ b_q[i]));
    end
  end

  assign acc_shift = (acc_q >> W) | (N'(slice_sum) << (N - W));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_q >> W;
        b_d     = b_q >> W;
        acc_d   = acc_shift;
        carry_d = slice_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NS - 1)) begin
          sum_d   = acc_shift;
          cout_d  = slice_c;
          ovf_d   = slice_cmsb ^ slice_c;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/rca_serial_adder.md
# rca_serial_adder

Sequential, handshaked responder for the ripple-carry adder transaction: it accepts one operand pair plus carry-in, then computes `W` bits per clock through an internal W-bit ripple slice with a registered carry. It returns `sum`, `cout` and a signed-overflow flag. It is a drop-in, area-reduced alternative to the combinational adder behind the wrap. Both transaction ends use valid/ready, so the existing testers drive and sample it without relying on timing assumptions.

## Interface
- `N`, default 4: operand/sum width in bits; N >= 2.
- `W`, default 1: bits processed per cycle; 1 <= W <= N and N % W == 0 (elaboration error otherwise).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  adder idle and able to accept operands.
- `a`  in  N  operand A; sampled only on the input handshake.
- `b`  in  N  operand B; sampled only on the input handshake.
- `cin`  in  1  carry-in; sampled only on the input handshake.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  N  a + b + cin, modulo 2^N.
- `cout`  out  1  carry out of bit N-1.
- `ovf`  out  1  two's-complement overflow: carry into bit N-1 XOR `cout`.

## Operation
- **State machine:** IDLE, BUSY, DONE.
- **IDLE:**
  - `in_ready` = 1, `out_valid` = 0.
  - On `in_valid && in_ready`: latch `a`, `b`, `cin` into shift registers. Set the carry register to `cin`, the slice counter to 0, and the sum register to 0. Go to BUSY.
- **BUSY:**
  - `in_ready` = 0, `out_valid` = 0.
  - Each cycle, take the low W bits of the A and B registers plus the carry register and add them through a W-bit ripple chain.
  - Shift the W result bits into the top of the sum register; the sum register fills LSB-first via right-shift.
  - Shift A and B right by W and update the carry register with the slice carry-out. Increment the counter.
  - On the slice where counter == N/W-1: capture the carry into bit N-1 (the internal ripple carry at slice position W-1) for `ovf`, then go to DONE.
- **DONE:**
  - `out_valid` = 1; `sum`, `cout` and `ovf` are stable.
  - `in_valid` is ignored.
  - On `out_valid && out_ready`, go to IDLE.
- **Result definition:** `{cout, sum} = a + b + cin` (N+1-bit unsigned). `ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1])`.
- **Output stability:**
  - `sum`, `cout` and `ovf` are registered. They change only on the cycle entering DONE, and hold their values until the next entry into DONE.
  - In IDLE and BUSY they show the previous result; they are 0 after reset.
- **No overlap:** a new transaction is never accepted while BUSY or DONE.
- **Operand isolation:** changes on `a`, `b` or `cin` after the handshake have no effect.

## Timing
- **Reset (`rst_n` low):**
  - Enters IDLE immediately, asynchronously.
  - Output values: `in_ready` = 1, `out_valid` = 0, `sum` = 0, `cout` = 0, `ovf` = 0.
  - Counter, carry and operand registers are 0.
- **Reset mid-transaction (BUSY or DONE):** the transaction is discarded and no `out_valid` pulse occurs. After release, the first edge with `in_valid` = 1 starts a new transaction.
- **Latency:**
  - The handshake on edge k moves to BUSY.
  - `out_valid` rises after edge k + N/W; N=4, W=1 gives 4 cycles.
  - Throughput is one result per N/W + 2 cycles with `out_ready` tied high.
- **Return path:** the output handshake on edge m moves to IDLE, and `in_ready` = 1 in the cycle after edge m. No same-cycle accept is allowed in DONE.
- **`in_valid`** may be held high continuously; only IDLE cycles are accepted.
- **Backpressure:** `out_ready` low holds DONE indefinitely with outputs unchanged.
- **W = N:** a single BUSY cycle (latency 1); behaviour is otherwise identical.

## Test plan
- **Carry ripple (N=4, W=1):** a=7, b=9, cin=0 → sum=0, cout=1, ovf=0; `out_valid` 4 cycles after accept.
- **Signed overflow (N=4, W=1):** a=5, b=3, cin=0 → sum=8, cout=0, ovf=1. a=8, b=8, cin=0 → sum=0, cout=1, ovf=1.
- **Carry-in path (N=4, W=1):** a=15, b=0, cin=1 → sum=0, cout=1, ovf=0. a=0, b=0, cin=1 → sum=1, cout=0.
- **Backpressure and isolation:**
  - Setup: a=6, b=2 accepted; `out_ready` held low 5 cycles; `a`/`b` toggled during BUSY.
  - Required: `out_valid` and sum=8 hold steady, and `in_ready` stays 0.
  - Release: after `out_ready`, `in_ready` = 1 the next cycle.
- **Multi-bit slice (N=8, W=2):** a=200, b=100, cin=1 → sum=45, cout=1, ovf=0; latency 4. Random sweep over 1000 vectors matches the reference model with zero mismatches.
- **Reset mid-operation:**
  - Setup: assert `rst_n` low during the 2nd BUSY cycle.
  - Required: `in_ready` = 1 and all outputs 0 immediately, with no `out_valid` pulse.
  - Follow-up: the next transaction a=1, b=1 → sum=2.
